// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if : cache-master request/beat signals and BurstRAM port bundle
// Revision 1.0
`default_nettype none

interface burst_ram_arbiter_if #(
   parameter int DW = 4,
   parameter int BW = 64
);
   logic            m0_cmd;
   logic            m0_cmd_en;
   logic [DW-1:0]   m0_addr;
   logic [BW-1:0]   m0_wr_data;
   logic [BW/8-1:0] m0_data_mask;
   logic            m0_ack;
   logic            m0_busy;
   logic [BW-1:0]   m0_rd_data;
   logic            m0_rd_data_valid;

   logic            m1_cmd;
   logic            m1_cmd_en;
   logic [DW-1:0]   m1_addr;
   logic [BW-1:0]   m1_wr_data;
   logic [BW/8-1:0] m1_data_mask;
   logic            m1_ack;
   logic            m1_busy;
   logic [BW-1:0]   m1_rd_data;
   logic            m1_rd_data_valid;

   logic            br_cmd;
   logic            br_cmd_en;
   logic [DW-1:0]   br_addr;
   logic [BW-1:0]   br_wr_data;
   logic [BW/8-1:0] br_data_mask;
   logic [BW-1:0]   br_rd_data;
   logic            br_rd_data_valid;
   logic            br_busy;
   logic            err_stray;

   // Arbiter view
   modport slave (
      input  m0_cmd, m0_cmd_en, m0_addr, m0_wr_data, m0_data_mask,
      output m0_ack, m0_busy, m0_rd_data, m0_rd_data_valid,
      input  m1_cmd, m1_cmd_en, m1_addr, m1_wr_data, m1_data_mask,
      output m1_ack, m1_busy, m1_rd_data, m1_rd_data_valid,
      output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
      input  br_rd_data, br_rd_data_valid, br_busy,
      output err_stray
   );

   // Cache-master / RAM-model view
   modport master (
      output m0_cmd, m0_cmd_en, m0_addr, m0_wr_data, m0_data_mask,
      input  m0_ack, m0_busy, m0_rd_data, m0_rd_data_valid,
      output m1_cmd, m1_cmd_en, m1_addr, m1_wr_data, m1_data_mask,
      input  m1_ack, m1_busy, m1_rd_data, m1_rd_data_valid,
      input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
      output br_rd_data, br_rd_data_valid, br_busy,
      input  err_stray
   );
endinterface

`default_nettype wire

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter : round-robin whole-burst arbiter sharing one BurstRAM port between two caches
// Revision 1.0
`default_nettype none

module burst_ram_arbiter #(
   parameter int RAM_DEPTH_BITWIDTH      = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_BURST_DATA_COUNT    = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   burst_ram_arbiter_if.slave bus
);

   localparam int DW = RAM_DEPTH_BITWIDTH;
   localparam int BW = RAM_BURST_DATA_BITWIDTH;
   localparam int MW = BW / 8;
   localparam int CW = $clog2(RAM_BURST_DATA_COUNT + 1);

   localparam logic [CW-1:0] c_BEATS   = CW'(RAM_BURST_DATA_COUNT);
   localparam logic [CW-1:0] c_LAST_RD = CW'(RAM_BURST_DATA_COUNT - 1);
   localparam logic [CW-1:0] c_ONE     = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR_BEATS = 2'd1,
      S_RD_BEATS = 2'd2,
      S_DRAIN    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_owner_vld;
   logic            r_owner;
   logic            r_rr_last;
   logic [CW-1:0]   r_beat_cnt;

   logic            r_ack0;
   logic            r_ack1;
   logic            r_br_cmd;
   logic            r_br_cmd_en;
   logic [DW-1:0]   r_br_addr;
   logic [BW-1:0]   r_br_wr_data;
   logic [MW-1:0]   r_br_data_mask;
   logic            r_err_stray;

   logic            w_grant;
   logic            w_winner;
   logic            w_win_cmd;
   logic [DW-1:0]   w_win_addr;
   logic [BW-1:0]   w_win_wdata;
   logic [MW-1:0]   w_win_mask;
   logic [BW-1:0]   w_own_wdata;
   logic [MW-1:0]   w_own_mask;
   logic            w_wr_fwd;
   logic            w_rd_beat;
   logic            w_rd_last;
   logic [BW-1:0]   w_wr_data_nxt;
   logic [MW-1:0]   w_mask_nxt;

   // Arbitration: a lone requester wins; on a tie the master that did not win last time wins.
   assign w_grant     = (r_state == S_IDLE) && !bus.br_busy && (bus.m0_cmd_en || bus.m1_cmd_en);
   assign w_winner    = (bus.m0_cmd_en && bus.m1_cmd_en) ? ~r_rr_last : bus.m1_cmd_en;

   assign w_win_cmd   = w_winner ? bus.m1_cmd       : bus.m0_cmd;
   assign w_win_addr  = w_winner ? bus.m1_addr      : bus.m0_addr;
   assign w_win_wdata = w_winner ? bus.m1_wr_data   : bus.m0_wr_data;
   assign w_win_mask  = w_winner ? bus.m1_data_mask : bus.m0_data_mask;
   assign w_own_wdata = r_owner  ? bus.m1_wr_data   : bus.m0_wr_data;
   assign w_own_mask  = r_owner  ? bus.m1_data_mask : bus.m0_data_mask;

   // Write counter holds the index of the next beat to forward; reaching c_BEATS ends the burst.
   assign w_wr_fwd    = (r_state == S_WR_BEATS) && (r_beat_cnt != c_BEATS);
   assign w_rd_beat   = (r_state == S_RD_BEATS) && bus.br_rd_data_valid;
   assign w_rd_last   = w_rd_beat && (r_beat_cnt == c_LAST_RD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_wr_data_nxt = '0;
      w_mask_nxt    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt = w_win_cmd ? S_WR_BEATS : S_RD_BEATS;
               if (w_win_cmd) begin
                  w_wr_data_nxt = w_win_wdata;
                  w_mask_nxt    = w_win_mask;
               end
            end
         end
         S_WR_BEATS: begin
            if (w_wr_fwd) begin
               w_wr_data_nxt = w_own_wdata;
               w_mask_nxt    = w_own_mask;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_RD_BEATS: begin
            if (w_rd_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!bus.br_busy) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner_vld    <= 1'b0;
         r_owner        <= 1'b0;
         r_rr_last      <= 1'b1;
         r_beat_cnt     <= '0;
         r_ack0         <= 1'b0;
         r_ack1         <= 1'b0;
         r_br_cmd       <= 1'b0;
         r_br_cmd_en    <= 1'b0;
         r_br_addr      <= '0;
         r_br_wr_data   <= '0;
         r_br_data_mask <= '0;
         r_err_stray    <= 1'b0;
      end else begin
         r_br_cmd_en    <= w_grant;
         r_ack0         <= w_grant && !w_winner;
         r_ack1         <= w_grant && w_winner;
         r_br_wr_data   <= w_wr_data_nxt;
         r_br_data_mask <= w_mask_nxt;

         if (w_grant) begin
            r_owner_vld <= 1'b1;
            r_owner     <= w_winner;
            r_rr_last   <= w_winner;
            r_br_cmd    <= w_win_cmd;
            r_br_addr   <= w_win_addr;
            r_beat_cnt  <= w_win_cmd ? c_ONE : '0;
         end else if (w_wr_fwd || w_rd_beat) begin
            r_beat_cnt  <= r_beat_cnt + c_ONE;
         end

         if ((r_state == S_DRAIN) && !bus.br_busy) begin
            r_owner_vld <= 1'b0;
         end

         if (bus.br_rd_data_valid && (r_state != S_RD_BEATS)) begin
            r_err_stray <= 1'b1;
         end
      end
   end

   assign bus.m0_ack           = r_ack0;
   assign bus.m1_ack           = r_ack1;
   assign bus.br_cmd           = r_br_cmd;
   assign bus.br_cmd_en        = r_br_cmd_en;
   assign bus.br_addr          = r_br_addr;
   assign bus.br_wr_data       = r_br_wr_data;
   assign bus.br_data_mask     = r_br_data_mask;
   assign bus.err_stray        = r_err_stray;

   assign bus.m0_rd_data       = bus.br_rd_data;
   assign bus.m1_rd_data       = bus.br_rd_data;
   assign bus.m0_rd_data_valid = w_rd_beat && r_owner_vld && !r_owner;
   assign bus.m1_rd_data_valid = w_rd_beat && r_owner_vld &&  r_owner;

   assign bus.m0_busy = ((r_state != S_IDLE) && !(r_owner_vld && !r_owner))
                        || bus.br_busy || (r_state == S_DRAIN);
   assign bus.m1_busy = ((r_state != S_IDLE) && !(r_owner_vld &&  r_owner))
                        || bus.br_busy || (r_state == S_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter : directed and randomized checks of burst_ram_arbiter against a transaction-level model
// Revision 1.0
`default_nettype none

module tb_burst_ram_arbiter;

   localparam int DW = 4;
   localparam int BW = 64;
   localparam int MW = BW / 8;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_grant_cyc = 0;

   // Reference model state: who won the previous grant, and the pending request of each master.
   logic            m_rr_last = 1'b1;
   logic            req_cmd  [2];
   logic [DW-1:0]   req_addr [2];
   logic [BW-1:0]   req_wd   [2];
   logic [MW-1:0]   req_mask [2];

   burst_ram_arbiter_if #(.DW(DW), .BW(BW)) bus ();

   burst_ram_arbiter #(
      .RAM_DEPTH_BITWIDTH      (DW),
      .RAM_BURST_DATA_BITWIDTH (BW),
      .RAM_BURST_DATA_COUNT    (NB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick(input logic r0, input logic r1);
      if (r0 && r1) return ~m_rr_last;
      return r1;
   endfunction

   task automatic idle_inputs();
      bus.m0_cmd = 0; bus.m0_cmd_en = 0; bus.m0_addr = '0; bus.m0_wr_data = '0; bus.m0_data_mask = '0;
      bus.m1_cmd = 0; bus.m1_cmd_en = 0; bus.m1_addr = '0; bus.m1_wr_data = '0; bus.m1_data_mask = '0;
      bus.br_rd_data = '0; bus.br_rd_data_valid = 0; bus.br_busy = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_rr_last = 1'b1;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_ctl"}, {bus.m0_ack, bus.m1_ack, bus.br_cmd_en, bus.br_cmd,
                          bus.m0_rd_data_valid, bus.m1_rd_data_valid, bus.err_stray}, 0);
      chk({tag, "_busy"}, {bus.m0_busy, bus.m1_busy}, 0);
      chk({tag, "_addr"}, bus.br_addr, 0);
      chk({tag, "_wdata"}, bus.br_wr_data, 0);
      chk({tag, "_mask"}, bus.br_data_mask, 0);
   endtask

   task automatic request(input logic who, input logic cmd, input logic [DW-1:0] a,
                          input logic [BW-1:0] d, input logic [MW-1:0] m);
      req_cmd[who] = cmd; req_addr[who] = a; req_wd[who] = d; req_mask[who] = m;
      if (who) begin
         bus.m1_cmd = cmd; bus.m1_addr = a; bus.m1_wr_data = d; bus.m1_data_mask = m; bus.m1_cmd_en = 1;
      end else begin
         bus.m0_cmd = cmd; bus.m0_addr = a; bus.m0_wr_data = d; bus.m0_data_mask = m; bus.m0_cmd_en = 1;
      end
   endtask

   task automatic drop(input logic who);
      if (who) bus.m1_cmd_en = 0;
      else     bus.m0_cmd_en = 0;
   endtask

   // Waits (bounded) for the next br_cmd_en and checks it against the model's expected winner.
   task automatic expect_grant(input string tag, input logic r0, input logic r1,
                               output logic who, output int lat);
      logic seen;
      seen = 0;
      lat  = 0;
      who  = pick(r0, r1);
      for (int n = 0; n < 40; n++) begin
         tick();
         if (bus.br_cmd_en === 1'b1) begin
            seen = 1;
            lat  = n + 1;
            break;
         end
      end
      last_grant_cyc = cyc;
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_ack"}, {bus.m0_ack, bus.m1_ack}, who ? 2'b01 : 2'b10);
      chk({tag, "_cmdaddr"}, {bus.br_cmd, bus.br_addr}, {req_cmd[who], req_addr[who]});
      chk({tag, "_beat0"}, {bus.br_wr_data, bus.br_data_mask},
          req_cmd[who] ? {req_wd[who], req_mask[who]} : '0);
      chk({tag, "_busy"}, {bus.m0_busy, bus.m1_busy}, who ? 2'b10 : 2'b01);
      m_rr_last = who;
   endtask

   task automatic rd_burst(input string tag, input logic who, input int n);
      logic [BW-1:0] d;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         d = {$urandom, $urandom};
         bus.br_rd_data = d;
         bus.br_rd_data_valid = 1;
         #1;
         chk({tag, "_rdv"}, {bus.m0_rd_data_valid, bus.m1_rd_data_valid}, who ? 2'b01 : 2'b10);
         chk({tag, "_rdd"}, who ? bus.m1_rd_data : bus.m0_rd_data, d);
         tick();
         bus.br_rd_data_valid = 0;
         bus.br_rd_data = '0;
      end
   endtask

   // Beat k is driven in the cycle after beat k-1 appears on the RAM bus.
   task automatic wr_burst(input string tag, input logic who);
      logic [BW-1:0] d;
      logic [MW-1:0] m;
      for (int k = 1; k < NB; k++) begin
         d = {$urandom, $urandom};
         m = MW'($urandom);
         if (who) begin bus.m1_wr_data = d; bus.m1_data_mask = m; end
         else     begin bus.m0_wr_data = d; bus.m0_data_mask = m; end
         tick();
         chk({tag, "_beat"}, {bus.br_wr_data, bus.br_data_mask}, {d, m});
         chk({tag, "_nocmd"}, bus.br_cmd_en, 0);
      end
      if (who) begin bus.m1_wr_data = {$urandom, $urandom}; bus.m1_data_mask = '1; end
      else     begin bus.m0_wr_data = {$urandom, $urandom}; bus.m0_data_mask = '1; end
      tick();
      chk({tag, "_after"}, {bus.br_wr_data, bus.br_data_mask}, 0);
      chk({tag, "_drain_busy"}, {bus.m0_busy, bus.m1_busy}, 2'b11);
   endtask

   initial begin
      logic who;
      int   lat;
      int   g0;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      m_rr_last = 1'b1;
      check_quiet("reset");

      // 1: lone M0 read at address 3
      request(0, 0, 4'd3, {$urandom, $urandom}, '0);
      expect_grant("t1", 1, 0, who, lat);
      chk("t1_latency", lat, 1);
      drop(0);
      tick();
      chk("t1_pulse", {bus.br_cmd_en, bus.m0_ack, bus.m1_ack}, 0);
      rd_burst("t1", 0, NB);
      chk("t1_drain", {bus.m0_busy, bus.m1_busy}, 2'b11);

      // 2: M1 write at address 5, RAM stays busy afterwards, M0 waits
      request(1, 1, 4'd5, {$urandom, $urandom}, 8'hFF);
      expect_grant("t2", 0, 1, who, lat);
      drop(1);
      bus.br_busy = 1;
      request(0, 0, 4'($urandom), '0, '0);
      wr_burst("t2", 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold", {bus.br_cmd_en, bus.m0_busy}, 2'b01);
      end
      bus.br_busy = 0;
      expect_grant("t2g", 1, 0, who, lat);
      chk("t2_latency", lat, 2);
      drop(0);
      rd_burst("t2r", 0, NB);

      // 3: simultaneous reads after reset, then alternation
      do_reset();
      request(0, 0, 4'($urandom), '0, '0);
      request(1, 0, 4'($urandom), '0, '0);
      expect_grant("t3a", 1, 1, who, lat);
      chk("t3a_first", who, 0);
      drop(0);
      rd_burst("t3a", 0, NB);
      expect_grant("t3b", 0, 1, who, lat);
      request(1, 0, 4'($urandom), '0, '0);
      request(0, 0, 4'($urandom), '0, '0);
      rd_burst("t3b", 1, NB);
      expect_grant("t3c", 1, 1, who, lat);
      drop(0);
      drop(1);
      rd_burst("t3c", who, NB);

      // Back-to-back: M0 write, M1 waiting; pulse gap is burst length + 2
      request(0, 1, 4'($urandom), {$urandom, $urandom}, MW'($urandom));
      expect_grant("gw", 1, 0, who, lat);
      g0 = last_grant_cyc;
      drop(0);
      request(1, 0, 4'($urandom), '0, '0);
      wr_burst("gw", 0);
      expect_grant("gr", 0, 1, who, lat);
      chk("gap", last_grant_cyc - g0, NB + 2);
      drop(1);
      rd_burst("gr", 1, NB);
      tick();

      // 4: request while RAM busy for 10 cycles
      bus.br_busy = 1;
      request(0, 0, 4'($urandom), '0, '0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold", {bus.br_cmd_en, bus.m0_busy, bus.m1_busy}, 3'b011);
      end
      bus.br_busy = 0;
      expect_grant("t4", 1, 0, who, lat);
      chk("t4_latency", lat, 1);
      drop(0);

      // 5: reset after 2 of 4 read beats
      rd_burst("t5", 0, 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_rr_last = 1'b1;
      check_quiet("t5_rst");
      for (int i = 0; i < 2; i++) begin
         bus.br_rd_data = {$urandom, $urandom};
         bus.br_rd_data_valid = 1;
         #1;
         chk("t5_nofwd", {bus.m0_rd_data_valid, bus.m1_rd_data_valid}, 0);
         tick();
         bus.br_rd_data_valid = 0;
         chk("t5_err", bus.err_stray, 1);
      end
      request(1, 0, 4'($urandom), '0, '0);
      expect_grant("t5g", 0, 1, who, lat);
      drop(1);
      rd_burst("t5r", 1, NB);
      chk("t5_err_sticky", bus.err_stray, 1);

      // 6: stray beat in IDLE
      do_reset();
      tick();
      chk("t6_clear", bus.err_stray, 0);
      bus.br_rd_data = {$urandom, $urandom};
      bus.br_rd_data_valid = 1;
      #1;
      chk("t6_nofwd", {bus.m0_rd_data_valid, bus.m1_rd_data_valid}, 0);
      tick();
      bus.br_rd_data_valid = 0;
      chk("t6_err", bus.err_stray, 1);
      repeat (3) tick();
      chk("t6_sticky", bus.err_stray, 1);
      do_reset();
      chk("t6_reset", bus.err_stray, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
